lut_builder: RTL and testbench



---
 rtl/lut_builder.sv | 95 +++++++++
 tb/tb_lut_builder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lut_builder.sv
// lut_builder: sequential key/data pair writer driving a packed lookup bus for keyed muxes.
// Define LUT_BUILDER_OVERWRITE_EN to update an existing key in place instead of appending.
module lut_builder #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 8,
  localparam int PAIR_LEN = KEY_LEN + DATA_LEN,
  localparam int CW       = $clog2(NR_KEY + 1),
  localparam int IW       = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [KEY_LEN-1:0]         in_key,
  input  logic [DATA_LEN-1:0]        in_data,
  output logic [NR_KEY*PAIR_LEN-1:0] lut,
  output logic [CW-1:0]              count,
  output logic                       full,
  output logic                       err
);
  typedef enum logic {IDLE, COMMIT} state_t;
  state_t state, state_nx;
  logic [KEY_LEN-1:0]         key_q [NR_KEY];
  logic [DATA_LEN-1:0]        data_q [NR_KEY];
  logic [NR_KEY-1:0]          vld_q;
  logic [KEY_LEN-1:0]         stg_key;
  logic [DATA_LEN-1:0]        stg_data;
  logic [NR_KEY*PAIR_LEN-1:0] lut_nx;
  logic                       hit, commit;
  logic [IW-1:0]              hit_idx, wr_idx;
`ifdef LUT_BUILDER_OVERWRITE_EN
  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NR_KEY - 1; i >= 0; i--)
      if (vld_q[i] && key_q[i] == stg_key) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
  end
`else
  assign hit = 1'b0;
  assign hit_idx = '0;
`endif
  assign full = count == CW'(NR_KEY);
  assign wr_idx = IW'(count);
  always_comb begin
    in_ready = state == IDLE;
    commit = state == COMMIT && !clear;
    err = commit && !hit && full;
    state_nx = (!clear && state == IDLE && in_valid) ? COMMIT : IDLE;
  end
  // Empty slots mirror slot 0 so a mux never sees a stray key; slot 0 invalid means an empty table.
  always_comb begin
    lut_nx = '0;
    for (int n = 0; n < NR_KEY; n++)
      lut_nx[PAIR_LEN*n +: PAIR_LEN] = vld_q[n] ? {key_q[n], data_q[n]} :
                                       vld_q[0] ? {key_q[0], data_q[0]} : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      vld_q <= '0;
      stg_key <= '0;
      stg_data <= '0;
      lut <= '0;
      for (int n = 0; n < NR_KEY; n++) begin
        key_q[n] <= '0;
        data_q[n] <= '0;
      end
    end else begin
      state <= state_nx;
      lut <= lut_nx;
      if (clear) begin
        vld_q <= '0;
        count <= '0;
      end else if (state == IDLE && in_valid) begin
        stg_key <= in_key;
        stg_data <= in_data;
      end else if (commit) begin
        if (hit) data_q[hit_idx] <= stg_data;
        else if (!full) begin
          key_q[wr_idx] <= stg_key;
          data_q[wr_idx] <= stg_data;
          vld_q[wr_idx] <= 1'b1;
          count <= count + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lut_builder.sv
// tb_lut_builder: random and directed stimulus for lut_builder checked against a table-level model.
module tb_lut_builder;
  localparam int NK = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_key = '0;
  logic [7:0]  in_data = '0;
  logic [47:0] lut;
  logic [2:0]  count;
  logic        full, err;
  int vecs = 0;
  int errs = 0;
  logic        last_err;

  lut_builder #(.NR_KEY(NK), .KEY_LEN(4), .DATA_LEN(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_key(in_key), .in_data(in_data), .lut(lut), .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  // Model: the table is an ordered list of pairs, mn entries long.
  logic [3:0]  mk [NK];
  logic [7:0]  md [NK];
  int          mn;
  bit          busy;
  logic [3:0]  sk;
  logic [7:0]  sd;
  logic [47:0] mlut;

  function automatic int find_key();
`ifdef LUT_BUILDER_OVERWRITE_EN
    for (int i = 0; i < mn; i++) if (mk[i] == sk) return i;
`endif
    return -1;
  endfunction

  function automatic logic [47:0] pack_table();
    logic [47:0] p = '0;
    for (int n = 0; n < NK; n++)
      p[12*n +: 12] = n < mn ? {mk[n], md[n]} : mn > 0 ? {mk[0], md[0]} : 12'h0;
    return p;
  endfunction

  function automatic logic [7:0] mux_out(logic [47:0] l, logic [3:0] k);
    logic [7:0] o = '0;
    for (int n = 0; n < NK; n++) if (l[12*n+8 +: 4] == k) o |= l[12*n +: 8];
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mn = 0;
      busy = 0;
      mlut = '0;
    end else begin
      mlut = pack_table();
      if (clear) begin
        mn = 0;
        busy = 0;
      end else if (busy) begin
        int h;
        h = find_key();
        if (h >= 0) md[h] = sd;
        else if (mn < NK) begin
          mk[mn] = sk;
          md[mn] = sd;
          mn++;
        end
        busy = 0;
      end else if (in_valid) begin
        busy = 1;
        sk = in_key;
        sd = in_data;
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("count", 64'(count), 64'(mn));
      chk("full", 64'(full), 64'(mn == NK));
      chk("in_ready", 64'(in_ready), 64'(!busy));
      chk("err", 64'(err), 64'(busy && !clear && find_key() < 0 && mn == NK));
      chk("lut", 64'(lut), 64'(mlut));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [3:0] k, logic [7:0] d);
    in_valid = 1'b1;
    in_key = k;
    in_data = d;
    step();
    in_valid = 1'b0;
    #1 last_err = err;
    step();
  endtask

  initial begin
    repeat (3) step();
    #2 rst = 1'b0;
    chk("rst_lut", 64'(lut), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);
    step();
    send(4'h3, 8'h11);
    send(4'h5, 8'h22);
    step();
    chk("two_lut", 64'(lut), 64'h311_311_522_311);
    chk("two_count", 64'(count), 64'h2);
    send(4'h7, 8'h33);
    send(4'h8, 8'h44);
    chk("fill_full", 64'(full), 64'h1);
    send(4'h9, 8'h55);
    chk("drop_err", 64'(last_err), 64'h1);
    step();
    chk("drop_lut", 64'(lut), 64'h844_733_522_311);
    send(4'h5, 8'h77);
    step();
`ifdef LUT_BUILDER_OVERWRITE_EN
    chk("ovw_err", 64'(last_err), 64'h0);
    chk("ovw_lut", 64'(lut), 64'h844_733_577_311);
`else
    chk("ovw_err", 64'(last_err), 64'h1);
    chk("ovw_lut", 64'(lut), 64'h844_733_522_311);
`endif
    chk("ovw_count", 64'(count), 64'h4);
    clear = 1'b1;
    step();
    clear = 1'b0;
    send(4'h2, 8'h0F);
    send(4'h2, 8'hF0);
    step();
`ifdef LUT_BUILDER_OVERWRITE_EN
    chk("dup_mux", 64'(mux_out(lut, 4'h2)), 64'hF0);
    chk("dup_count", 64'(count), 64'h1);
`else
    chk("dup_mux", 64'(mux_out(lut, 4'h2)), 64'hFF);
    chk("dup_count", 64'(count), 64'h2);
`endif
    in_valid = 1'b1;
    in_key = 4'hA;
    in_data = 8'hAA;
    step();
    in_valid = 1'b0;
    clear = 1'b1;
    #1 chk("clr_err", 64'(err), 64'h0);
    step();
    clear = 1'b0;
    chk("clr_count", 64'(count), 64'h0);
    step();
    chk("clr_lut", 64'(lut), 64'h0);
    send(4'h1, 8'hA1);
    send(4'h4, 8'hB2);
    #2 rst = 1'b1;
    #1;
    chk("arst_lut", 64'(lut), 64'h0);
    chk("arst_count", 64'(count), 64'h0);
    chk("arst_full", 64'(full), 64'h0);
    chk("arst_err", 64'(err), 64'h0);
    #3 rst = 1'b0;
    step();
    send(4'hC, 8'h3C);
    step();
    chk("arst_slot0", 64'(lut), 64'hC3C_C3C_C3C_C3C);
    chk("arst_cnt1", 64'(count), 64'h1);
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 24) == 0);
      in_key = 4'($urandom_range(0, 7));
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    clear = 1'b0;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
